// File: rtl/seq_to_sim_frame_reg_n_if.sv
// Beat input, frame output and handshake bundle for the frame collector.
// slave is the collector side; master is the producer/consumer side.
interface seq_to_sim_frame_reg_n_if #(
  parameter int BIT_WIDTH = 2,
  parameter int CH_NUM    = 1,
  parameter int SHIFT_LEN = 4
);
  localparam int SLOT_W  = BIT_WIDTH * CH_NUM;
  localparam int FRAME_W = SLOT_W * SHIFT_LEN;
  localparam int CNT_W   = $clog2(SHIFT_LEN + 1);

  logic               in_ctr_en;
  logic               in_ctr_last;
  logic [SLOT_W-1:0]  in;
  logic               out_ctr_rdy;
  logic               out_ctr_valid;
  logic               in_ctr_ack;
  logic [FRAME_W-1:0] out;
  logic [CNT_W-1:0]   out_ctr_len;
  logic               out_ctr_trunc;

  modport slave (
    input  in_ctr_en, in_ctr_last, in, in_ctr_ack,
    output out_ctr_rdy, out_ctr_valid, out, out_ctr_len, out_ctr_trunc
  );

  modport master (
    output in_ctr_en, in_ctr_last, in, in_ctr_ack,
    input  out_ctr_rdy, out_ctr_valid, out, out_ctr_len, out_ctr_trunc
  );
endinterface

// File: rtl/seq_to_sim_frame_reg_n.sv
// Multi-channel serial-to-parallel frame collector with a registered, handshaked
// output frame; the next frame keeps filling while the previous one is pending.
module seq_to_sim_frame_reg_n #(
  parameter int DIRECTION = 1,
  parameter int SHIFT_LEN = 4,
  parameter int BIT_WIDTH = 2,
  parameter int CH_NUM    = 1
) (
  input  logic                   clk,
  input  logic                   in_ctr_Arst,
  input  logic                   in_ctr_Srst,
  seq_to_sim_frame_reg_n_if.slave bus
);
  localparam int SLOT_W  = BIT_WIDTH * CH_NUM;
  localparam int FRAME_W = SLOT_W * SHIFT_LEN;
  localparam int CNT_W   = $clog2(SHIFT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_LEN - 1);
  localparam bit MSB_FIRST = DIRECTION > 0;

  logic [FRAME_W-1:0] coll_q, coll_ins, out_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc, slot_idx, len_q;
  logic               valid_q, trunc_q;
  logic               rdy, accept, close;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign slot_idx = MSB_FIRST ? CNT_MAX - cnt_q : cnt_q;

  // Only a closing beat has to wait for the pending frame to be acknowledged.
  assign rdy    = ~valid_q | bus.in_ctr_ack | (~bus.in_ctr_last & (cnt_q < CNT_MAX));
  assign accept = bus.in_ctr_en & rdy;
  assign close  = accept & (bus.in_ctr_last | (cnt_q == CNT_MAX));

  // Collector is zero outside filled slots, so unfilled output slots come out as 0.
  always_comb begin
    coll_ins = coll_q;
    for (int s = 0; s < SHIFT_LEN; s++) begin
      if (CNT_W'(s) == slot_idx) coll_ins[s*SLOT_W +: SLOT_W] = bus.in;
    end
  end

  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      coll_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (in_ctr_Srst) begin
      coll_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (close) begin
        coll_q  <= '0;
        cnt_q   <= '0;
        out_q   <= coll_ins;
        len_q   <= cnt_inc;
        trunc_q <= ~bus.in_ctr_last;
        valid_q <= 1'b1;
      end else begin
        if (accept) begin
          coll_q <= coll_ins;
          cnt_q  <= cnt_inc;
        end
        if (valid_q & bus.in_ctr_ack) valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_ctr_rdy   = rdy;
  assign bus.out_ctr_valid = valid_q;
  assign bus.out           = out_q;
  assign bus.out_ctr_len   = len_q;
  assign bus.out_ctr_trunc = trunc_q;
endmodule

// File: doc/seq_to_sim_frame_reg_n.md
Name: seq_to_sim_frame_reg_n

Overview:
Multi-channel serial-to-parallel frame collector with a variable frame length and a buffered output. Each beat carries CH_NUM words of BIT_WIDTH bits. Beats are gathered into a frame of up to SHIFT_LEN slots. A completed frame is presented on a registered output with a valid/acknowledge handshake, while the collector keeps filling the next frame. It feeds the syndrome and key-equation stages that consume whole codeword chunks at once.

Parameters:
DIRECTION, 1, >0: first beat lands in the most-significant slot; <=0: first beat lands in slot 0 (LSB).
SHIFT_LEN, 4, maximum beats per frame (>=1).
BIT_WIDTH, 2, bits per channel word.
CH_NUM, 1, channels per beat (>=1).
CNT_W (localparam), clog2(SHIFT_LEN+1), width of the beat count.

Ports:
clk  input  1  clock; all registers update on its rising edge.
in_ctr_Arst  input  1  asynchronous, active-high reset.
in_ctr_Srst  input  1  synchronous clear; same effect as reset.
in_ctr_en  input  1  beat valid.
in_ctr_last  input  1  marks the final beat of a frame; qualified by in_ctr_en.
in  input  BIT_WIDTH*CH_NUM  beat data.
out_ctr_rdy  output  1  collector can accept the beat; combinational.
out_ctr_valid  output  1  output frame pending.
in_ctr_ack  input  1  consumer takes the output frame.
out  output  BIT_WIDTH*CH_NUM*SHIFT_LEN  registered frame; a slot is BIT_WIDTH*CH_NUM bits.
out_ctr_len  output  CNT_W  number of beats in the output frame (1..SHIFT_LEN).
out_ctr_trunc  output  1  frame closed by length, with no last seen.

Behaviour:
- Reset and clear:
  - in_ctr_Arst asynchronously clears collector, beat count, out, out_ctr_valid, out_ctr_len and out_ctr_trunc to 0.
  - in_ctr_Srst does the same at the clock edge and overrides a beat presented in that cycle, which is dropped.
  - A reset or clear mid-frame discards the partial frame; no stale data may reach a later frame.
- Accept: a beat is accepted when in_ctr_en & out_ctr_rdy. A beat presented with in_ctr_en & ~out_ctr_rdy causes no state change.
- Slot placement: beat k (0-based) of a frame is written to slot SHIFT_LEN-1-k when DIRECTION>0, and to slot k otherwise. Slot s occupies out[s*BIT_WIDTH*CH_NUM +: BIT_WIDTH*CH_NUM]. Channel c sits at bits [c*BIT_WIDTH +: BIT_WIDTH] within the slot.
- Frame close: an accepted beat closes the frame when in_ctr_last=1 or when beat count = SHIFT_LEN-1.
  - trunc = ~in_ctr_last on the closing beat.
  - SHIFT_LEN=1: every accepted beat closes a frame.
- Output load, latency 1: on the edge after the closing beat:
  - out takes the collector contents plus the closing beat, with unfilled slots forced to 0.
  - out_ctr_len takes the beat count, including the closing beat.
  - out_ctr_trunc is updated and out_ctr_valid is set to 1.
  - The collector and beat count clear to 0 on the same edge.
- Output hold: out, out_ctr_len and out_ctr_trunc stay stable while out_ctr_valid=1 and in_ctr_ack=0.
  - in_ctr_ack with valid and no simultaneous close: valid goes to 0 and out keeps its value.
  - in_ctr_ack with valid and a simultaneous close: the new frame loads and valid stays 1.
  - in_ctr_ack with valid=0 is ignored.
- Ready, combinational: out_ctr_rdy = ~out_ctr_valid | in_ctr_ack | (~in_ctr_last & (cnt < SHIFT_LEN-1)).
  - While a frame is pending, non-closing beats are still accepted.
  - Only a closing beat stalls until acknowledged.
- Count: internal cnt runs 0..SHIFT_LEN-1 and never wraps past it. Closing resets it to 0.

Test Plan:
(BIT_WIDTH=4, CH_NUM=2, SHIFT_LEN=4, DIRECTION=1 unless stated; out is 32 bits.)
1. Full frame: beats 0x11,0x22,0x33,0x44, last on the 4th -> next cycle out=0x11223344, len=4, trunc=0, valid=1. Ack -> valid=0, out unchanged.
2. Early last: beats 0xA1, then 0xB2 with last -> out=0xA1B20000, len=2, trunc=0. Same stimulus with DIRECTION=0 -> out=0x0000B2A1.
3. Length close: 0x01,0x02,0x03,0x04 with no last -> out=0x01020304, trunc=1. A 5th beat 0x05 starts a new frame; internal cnt=1.
4. Backpressure: frame pending and ack=0; 3 non-last beats are accepted with rdy=1. 4th beat has rdy=0 and is held 3 cycles -> out unchanged. Assert ack -> beat accepted that cycle; next cycle new frame loaded and valid stays 1.
5. Mid-frame reset: after beats 0x77,0x88, pulse in_ctr_Arst between edges -> out=0, valid=0 immediately. Then beats 0x11,0x22(last) -> out=0x11220000, len=2. Repeat with in_ctr_Srst asserted while in_ctr_en=1 -> that beat dropped.
6. SHIFT_LEN=1, CH_NUM=3, BIT_WIDTH=4: beats 0xABC,0x123 back-to-back with ack tied 1 -> out=0xABC then 0x123 on consecutive cycles, len=1 each, trunc=1 (no last).
